// File: rtl/modsub_pkg.sv
// rtl/modsub_pkg.sv - shared types, op encoding and round-robin pick for modsub_arbiter
//
// Contents:
//   DW            datapath width (operand/result/modulus)
//   MAX_REQ       widest requester vector rr_pick handles
//   MAX_ID_W      requester id width carried in a pipeline entry
//   OP_SUB/OP_ADD request op encoding
//   pipe_entry_t  one pipeline stage: {valid, id, op, data}
//   rr_pick       one-hot grant of the first set request at or above ptr, wrapping
package modsub_pkg;

  localparam int DW       = 32;
  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic                op;
    logic [DW-1:0]       data;
  } pipe_entry_t;

  // ptr < num_req and k < num_req, so a single conditional subtract wraps the index.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]  req,
                                                  input logic [MAX_ID_W-1:0] ptr,
                                                  input int                  num_req);
    logic [MAX_REQ-1:0]  grant;
    logic                found;
    logic [MAX_ID_W:0]   idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + (MAX_ID_W + 1)'(k);
      if (idx >= (MAX_ID_W + 1)'(num_req)) idx = idx - (MAX_ID_W + 1)'(num_req);
      if (k < num_req && !found && req[idx[MAX_ID_W-1:0]]) begin
        grant[idx[MAX_ID_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/modadd_sub_unit.sv
// rtl/modadd_sub_unit.sv - combinational modular add/subtract, operands assumed < q
//
// Ports:
//   a, b    operands, both expected in [0, q)
//   q       modulus
//   op      OP_SUB: (a - b) mod q, OP_ADD: (a + b) mod q
//   result  value in [0, q) for in-range operands
module modadd_sub_unit
  import modsub_pkg::*;
#(
  parameter int DATA_WIDTH = DW
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] q,
  input  logic                  op,
  output logic [DATA_WIDTH-1:0] result
);

  // One extra bit holds the borrow of the subtract and the carry of the add,
  // so a full-width q (e.g. 2^32-5) still reduces correctly.
  logic [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] sum_red;

  always_comb begin
    diff    = {1'b0, a} - {1'b0, b};
    sum     = {1'b0, a} + {1'b0, b};
    sum_red = sum - {1'b0, q};
    if (op == OP_ADD) begin
      result = (sum >= {1'b0, q}) ? DATA_WIDTH'(sum_red) : DATA_WIDTH'(sum);
    end else begin
      result = diff[DATA_WIDTH] ? DATA_WIDTH'(diff) + q : DATA_WIDTH'(diff);
    end
  end

endmodule

// File: rtl/modsub_arbiter.sv
// rtl/modsub_arbiter.sv - round-robin arbiter sharing one pipelined modular add/sub unit
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   modular      modulus q, held stable while busy
//   req_valid    per-requester request valid
//   req_ready    per-requester grant, one-hot or zero, combinational
//   req_op       per-requester op (0 sub, 1 add)
//   req_a/req_b  packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   resp_valid   result valid (registered, last pipeline stage)
//   resp_ready   consumer accepts result
//   resp_id      requester index of the result
//   resp_op      op of the result
//   resp_data    result in [0, q)
//   busy         any pipeline stage holds a valid operation
module modsub_arbiter
  import modsub_pkg::*;
#(
  parameter int DATA_WIDTH = DW,
  parameter int NUM_REQ    = 4,
  parameter int PIPE       = 2,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           modular,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [ID_W-1:0]                 resp_id,
  output logic                            resp_op,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            busy
);

  pipe_entry_t           stage [PIPE];
  logic [ID_W-1:0]       rr_ptr;
  logic                  stall;
  logic [NUM_REQ-1:0]    grant;
  logic                  xfer;
  logic [ID_W-1:0]       grant_id;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  sel_op;
  logic [DATA_WIDTH-1:0] result;

  // The whole pipeline freezes whenever the output is held, even if bubbles
  // upstream could have advanced; keeps the control to a single enable.
  assign stall = stage[PIPE-1].valid & ~resp_ready;

  always_comb begin
    grant = '0;
    if (!rst && !stall) begin
      grant = NUM_REQ'(rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(rr_ptr), NUM_REQ));
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  // Grant is one-hot, so this loop is a plain mux onto the shared datapath.
  always_comb begin
    grant_id = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_op   = OP_SUB;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        sel_a    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        sel_op   = req_op[i];
      end
    end
  end

  modadd_sub_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_modadd_sub_unit (
    .a      (sel_a),
    .b      (sel_b),
    .q      (modular),
    .op     (sel_op),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE; k++) begin
        stage[k] <= '0;
      end
    end else if (!stall) begin
      stage[0] <= '{valid: xfer,
                    id:    MAX_ID_W'(grant_id),
                    op:    sel_op,
                    data:  DW'(result)};
      for (int k = 1; k < PIPE; k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign resp_valid = stage[PIPE-1].valid;
  assign resp_id    = ID_W'(stage[PIPE-1].id);
  assign resp_op    = stage[PIPE-1].op;
  assign resp_data  = DATA_WIDTH'(stage[PIPE-1].data);

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < PIPE; k++) begin
      busy = busy | stage[k].valid;
    end
  end

endmodule

// File: tb/tb_modsub_arbiter.sv
// tb/tb_modsub_arbiter.sv - scoreboard bench for modsub_arbiter
module tb_modsub_arbiter;

  localparam int DWT  = 32;
  localparam int NREQ = 4;
  localparam int PIPE = 2;
  localparam int IDW  = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] exp;
  } op_t;

  typedef struct {
    int          id;
    logic        op;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DWT-1:0]         modular;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_op;
  logic [NREQ*DWT-1:0]    req_a;
  logic [NREQ*DWT-1:0]    req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [IDW-1:0]         resp_id;
  logic                   resp_op;
  logic [DWT-1:0]         resp_data;
  logic                   busy;

  modsub_arbiter #(
    .DATA_WIDTH(DWT), .NUM_REQ(NREQ), .PIPE(PIPE), .ID_W(IDW)
  ) dut (
    .clk(clk), .rst(rst), .modular(modular),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_op(resp_op), .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  op_t  pend [NREQ][$];
  op_t  cur  [NREQ];
  bit   taken [NREQ];
  exp_t exp_q [$];
  int   wt [NREQ];
  int   glog_id [$];
  int   glog_cyc [$];
  int   cyc = 0;
  bit   lat_en = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic op, input logic [31:0] q);
    longint unsigned la, lb, lq;
    la = 64'(a); lb = 64'(b); lq = 64'(q);
    if (op) return 32'((la + lb) % lq);
    return 32'((la + lq - lb) % lq);
  endfunction

  task automatic add_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] e);
    op_t o;
    o.a = a; o.b = b; o.op = op; o.exp = e;
    pend[r].push_back(o);
  endtask

  // Requester driver: holds each op stable until its transfer, then loads the next.
  initial begin
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) taken[i] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rst || taken[i]) begin
          req_valid[i] = 1'b0;
          taken[i] = 1'b0;
        end
        if (!rst && !req_valid[i] && pend[i].size() > 0) begin
          cur[i] = pend[i].pop_front();
          req_valid[i] = 1'b1;
          req_op[i] = cur[i].op;
          req_a[i*DWT +: DWT] = cur[i].a;
          req_b[i*DWT +: DWT] = cur[i].b;
        end
      end
    end
  end

  // Monitor: records transfers into the scoreboard and checks every response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        for (int i = 0; i < NREQ; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            e.id = i; e.op = cur[i].op; e.data = cur[i].exp; e.cyc = cyc;
            exp_q.push_back(e);
            taken[i] = 1'b1;
            glog_id.push_back(i);
            glog_cyc.push_back(cyc);
            for (int j = 0; j < NREQ; j++)
              if (j != i && req_valid[j]) wt[j]++;
            chk("fairness", 64'(wt[i] <= NREQ - 1), 64'(1));
            wt[i] = 0;
          end
        end
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            chk("stale_resp", 64'(resp_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("resp_id", 64'(resp_id), 64'(e.id));
            chk("resp_op", 64'(resp_op), 64'(e.op));
            chk("resp_data", 64'(resp_data), 64'(e.data));
            if (lat_en) chk("latency", 64'(cyc - e.cyc), 64'(PIPE));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int budget, input string tag);
    int  n;
    bit  idle;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      idle = (exp_q.size() == 0) && !busy && (req_valid == '0);
      for (int i = 0; i < NREQ; i++) if (pend[i].size() != 0) idle = 1'b0;
      n++;
    end while (!idle && n < budget);
    chk(tag, 64'(idle), 64'(1));
    @(posedge clk);
    #2;
  endtask

  initial begin
    int g0;
    int gstart;
    op_t o;
    rst = 1'b1; resp_ready = 1'b1; modular = 32'd97;
    for (int i = 0; i < NREQ; i++) wt[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;

    // Single ops and add wrap, q = 97
    lat_en = 1'b1;
    add_op(2, 32'd10, 32'd20, 1'b0, 32'd87);
    wait_idle(50, "idle_sub1");
    add_op(2, 32'd50, 32'd20, 1'b0, 32'd30);
    add_op(2, 32'd60, 32'd50, 1'b1, 32'd13);
    add_op(2, 32'd96, 32'd0,  1'b1, 32'd96);
    add_op(2, 32'd0,  32'd0,  1'b1, 32'd0);
    wait_idle(50, "idle_add");

    // Full-width modulus 2^32-5
    modular = 32'hFFFF_FFFB;
    add_op(1, 32'hFFFF_FFFA, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFF9);
    add_op(1, 32'h0000_0000, 32'hFFFF_FFFA, 1'b0, 32'h0000_0001);
    add_op(1, 32'hFFFF_FFFA, 32'h0000_0001, 1'b1, 32'h0000_0000);
    wait_idle(50, "idle_full");
    modular = 32'd97;

    // Backpressure with a full pipeline
    lat_en = 1'b0;
    add_op(1, 32'd1,  32'd1,  1'b1, 32'd2);
    add_op(1, 32'd2,  32'd2,  1'b1, 32'd4);
    add_op(1, 32'd3,  32'd3,  1'b1, 32'd6);
    add_op(1, 32'd4,  32'd4,  1'b1, 32'd8);
    add_op(3, 32'd90, 32'd10, 1'b1, 32'd3);
    add_op(3, 32'd80, 32'd30, 1'b1, 32'd13);
    add_op(3, 32'd10, 32'd30, 1'b0, 32'd77);
    add_op(3, 32'd96, 32'd96, 1'b0, 32'd0);
    for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
    chk("bp_first_resp", 64'(resp_valid), 64'(1));
    @(posedge clk); #2;
    resp_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); #1;
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      chk("bp_resp_valid", 64'(resp_valid), 64'(1));
      if (exp_q.size() > 0) begin
        chk("bp_hold_data", 64'(resp_data), 64'(exp_q[0].data));
        chk("bp_hold_id", 64'(resp_id), 64'(exp_q[0].id));
      end else begin
        chk("bp_queue", 64'(exp_q.size()), 64'(1));
      end
    end
    @(posedge clk); #2;
    resp_ready = 1'b1;
    wait_idle(100, "idle_bp");

    // Reset with two operations in flight
    resp_ready = 1'b0;
    gstart = glog_id.size();
    add_op(0, 32'd1, 32'd2, 1'b1, 32'd3);
    add_op(0, 32'd5, 32'd1, 1'b0, 32'd4);
    for (int n = 0; n < 20 && glog_id.size() < gstart + 2; n++) @(negedge clk);
    chk("rst_inflight", 64'(glog_id.size() - gstart), 64'(2));
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    @(negedge clk); #1;
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      pend[i].delete();
      wt[i] = 0;
    end
    @(posedge clk); #2;
    rst = 1'b0;
    resp_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("no_stale_valid", 64'(resp_valid), 64'(0));
    chk("no_stale_busy", 64'(busy), 64'(0));
    @(posedge clk); #2;

    // Round robin from rr_ptr = 0 after reset
    lat_en = 1'b1;
    g0 = glog_id.size();
    add_op(0, 32'd5,  32'd3,  1'b1, 32'd8);
    add_op(0, 32'd5,  32'd7,  1'b0, 32'd95);
    add_op(1, 32'd15, 32'd3,  1'b1, 32'd18);
    add_op(1, 32'd15, 32'd7,  1'b0, 32'd8);
    add_op(2, 32'd25, 32'd3,  1'b1, 32'd28);
    add_op(2, 32'd25, 32'd7,  1'b0, 32'd18);
    add_op(3, 32'd35, 32'd3,  1'b1, 32'd38);
    add_op(3, 32'd35, 32'd70, 1'b0, 32'd62);
    wait_idle(100, "idle_rr");
    chk("rr_count", 64'(glog_id.size() - g0), 64'(8));
    if (glog_id.size() >= g0 + 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("rr_grant_id", 64'(glog_id[g0 + k]), 64'(k % NREQ));
        chk("rr_grant_cycle", 64'(glog_cyc[g0 + k] - glog_cyc[g0]), 64'(k));
      end
    end

    // Random soak at q = 12289
    lat_en = 1'b0;
    modular = 32'd12289;
    for (int c = 0; c < 10000; c++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i].size() == 0 && $urandom_range(0, 1) == 1) begin
          o.a  = 32'($urandom_range(0, 12288));
          o.b  = 32'($urandom_range(0, 12288));
          o.op = 1'($urandom_range(0, 1));
          add_op(i, o.a, o.b, o.op, ref_op(o.a, o.b, o.op, 32'd12289));
        end
      end
      @(posedge clk); #2;
    end
    resp_ready = 1'b1;
    wait_idle(2000, "idle_soak");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/modsub_arbiter.md
Name: modsub_arbiter

Overview:
- Round-robin arbiter and pipeline controller that shares one modular add/subtract datapath among NUM_REQ requesters, e.g. butterfly stage engines and twiddle-update logic in the NTT/FFT core.
- Each requester issues (A, B, op) over a valid/ready handshake.
- Results return in issue order on a single response port, with a requester ID and response backpressure.
- Arithmetic: sub gives (A−B) mod q, add gives (A+B) mod q, with q supplied on the shared modular input.

Parameters:
DATA_WIDTH, 32, operand/result/modulus width (equals `DATA_WIDTH)
NUM_REQ, 4, number of requesters (2..8)
PIPE, 2, register stages after the arithmetic (1..4)
ID_W, 2, requester ID width, clog2(NUM_REQ)

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous active-high reset
modular  in  DATA_WIDTH  modulus q; must be held stable while busy=1
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_op  in  NUM_REQ  per-requester op: 0 = subtract, 1 = add
req_a  in  NUM_REQ*DATA_WIDTH  packed A operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_b  in  NUM_REQ*DATA_WIDTH  packed B operands, same packing
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_id  out  ID_W  requester index of the result
resp_op  out  1  op of the result
resp_data  out  DATA_WIDTH  result in [0, q)
busy  out  1  at least one operation in flight

Behaviour:
- Reset, synchronous (rst=1 at a clk edge):
  - All pipeline valid bits cleared; resp_valid=0, resp_id=0, resp_op=0, resp_data=0, busy=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst=1.
  - Any in-flight operation is discarded with no response.
- Arbitration:
  - stall = resp_valid & ~resp_ready.
  - When ~stall, grant the first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - req_ready is combinational from req_valid, rr_ptr and stall, and is 0 when stall=1.
  - Transfer on req_valid[i] & req_ready[i].
  - After a transfer from requester i, rr_ptr ← (i+1) mod NUM_REQ.
  - With no transfer, rr_ptr holds.
- Arithmetic, at issue (combinational), with operands A, B < q required:
  - Sub: C = A − B computed at DATA_WIDTH+1 bits. If bit DATA_WIDTH (borrow) is 1, result = C + q truncated to DATA_WIDTH; otherwise result = C.
  - Add: S = A + B computed at DATA_WIDTH+1 bits. If S ≥ q, result = S − q; otherwise result = S.
  - Operands ≥ q: undefined result, but no protocol effect.
- Pipeline:
  - {valid, id, op, data} advance through PIPE stages.
  - Latency from transfer to resp_valid is exactly PIPE cycles when no stall occurs.
  - The last stage drives the resp_* outputs directly as registers.
  - On stall, the whole pipeline freezes and no new grant is issued.
  - Bubbles are not squeezed.
  - Throughput is one operation per cycle when resp_ready=1.
- Ordering: responses leave in grant order; no reordering.
- busy: OR of all stage valid bits.
- Simultaneous events:
  - A transfer in the same cycle as a response handshake is allowed.
  - resp_ready deasserting while bubbles are in the pipeline still freezes the pipeline. This is intentional, for simplicity.
- Requester protocol:
  - Once asserted, req_valid and the operands stay stable until the transfer.
  - The arbiter never drops or duplicates a request.
- Fairness: a continuously requesting requester is granted within NUM_REQ grants.

Decomposition:
- Package modsub_pkg holds:
  - op encoding constants OP_SUB=1'b0 and OP_ADD=1'b1;
  - typedef pipe_entry_t {valid, id, op, data};
  - a function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module modadd_sub_unit: combinational add/sub with the borrow/compare correction above, selected by op. It is the only arithmetic instance.
- The arbiter, pipeline and stall logic stay in the top module.

Test Plan:
- Single sub, q=97: requester 2 sends A=10, B=20, op=0, resp_ready=1 → resp_valid exactly PIPE cycles later with resp_id=2 and resp_data=87. Same with A=50, B=20 → 30.
- Add wrap, q=97: A=60, B=50, op=1 → 13. A=96, B=0 → 96. A=0, B=0 → 0. Full-width case q=2^32−5, A=B=q−1, add → q−2, which exercises the carry bit.
- Round-robin: all 4 req_valid held high, rr_ptr=0, 8 back-to-back operations → grants 0,1,2,3,0,1,2,3, one per cycle, and resp_id follows the same sequence.
- Backpressure: resp_ready=0 for 5 cycles while the pipeline is full → req_ready=0 and resp_* held stable. On release, the stream continues with no loss, duplicates or reordering, checked against a scoreboard.
- Reset mid-operation: assert rst with 2 operations in flight → next cycle resp_valid=0, busy=0, rr_ptr=0, and no stale response appears after reset release.
- Random soak: random req_valid and resp_ready over 10k cycles at q=12289 → every request answered exactly once, results match the reference model, and no requester waits more than NUM_REQ grants.
